uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   - CLKS_PER_BIT_DEF : default clock cycles per bit (50 MHz / 115200 baud)
//   - DATA_BITS        : data bits per frame (8N1)
//   - STOP_BITS        : stop bits per frame
//   - rx_state_t       : receiver FSM state encoding
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset; both flops load RESET_VAL
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   uart_rxd     : asynchronous serial input
//   rx_ack       : consumer acknowledge, clears rx_valid and rx_overrun
//   rx_data      : last accepted byte
//   rx_valid     : rx_data holds an unacknowledged byte
//   rx_busy      : a frame is being received (FSM not idle)
//   rx_frame_err : one-cycle pulse when the stop bit is sampled low
//   rx_overrun   : sticky, a completed byte was dropped while rx_valid was high
//   rx_state     : current FSM state (debug observation)
//
// Handshake: rx_valid rises when a byte is accepted and stays high until a
// cycle in which rx_ack is high; that edge clears rx_valid unless a new byte
// completes in the same cycle, in which case the new byte replaces the old
// one and rx_valid stays high. rx_ack while rx_valid is low has no effect.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic [2:0] rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // The counter runs from the load value down to 0 inclusive, so a load of
  // N-1 spaces samples N cycles apart.
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 baud_zero;
  logic                 byte_done;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (uart_rxd),
    .q       (rxd_s)
  );

  assign baud_zero = (baud_cnt == '0);
  // Good stop bit sampled this cycle; the byte is handed off on this edge.
  assign byte_done = (state == RX_STOP) && baud_zero && rxd_s;

  assign rx_busy  = (state != RX_IDLE);
  assign rx_state = state;

  // Frame FSM and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RX_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxd_s) begin
            state    <= RX_START;
            bit_cnt  <= '0;
            baud_cnt <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (baud_zero) begin
            // Line back high at mid start bit is treated as a glitch.
            if (!rxd_s) begin
              state    <= RX_DATA;
              baud_cnt <= FULL_LOAD;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_zero) begin
            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
            baud_cnt  <= FULL_LOAD;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= RX_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_zero) begin
            if (rxd_s) begin
              state <= RX_IDLE;
            end else begin
              state        <= RX_WAIT_IDLE;
              rx_frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_WAIT_IDLE: begin
          // A held break must go high before a new start can be detected.
          if (rxd_s) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Output register and consumer handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
          if (rx_ack) begin
            rx_overrun <= 1'b0;
          end
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk;
  logic       reset_n;
  logic       uart_rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic [2:0] rx_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rxd     (uart_rxd),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_state     (rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitors: frame error pulse count/width and rx_valid rising edges
  int   ferr_pulses = 0;
  int   ferr_wide   = 0;
  int   valid_rises = 0;
  logic ferr_prev   = 1'b0;
  logic valid_prev  = 1'b0;

  always @(negedge clk) begin
    if (rx_frame_err && !ferr_prev) ferr_pulses++;
    if (rx_frame_err && ferr_prev)  ferr_wide++;
    if (rx_valid && !valid_prev)    valid_rises++;
    ferr_prev  = rx_frame_err;
    valid_prev = rx_valid;
  end

  // driver tasks: every step ends 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_bit;
    tick(CPB);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_byte(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'h0, rx_data}, {24'h0, e});
  endtask

  initial begin
    int n;
    int busy_cnt;
    int ferr0;
    int vr0;

    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    rx_ack   = 1'b0;

    // reset state
    tick(3);
    check("reset_outputs", {24'h0, rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun},
          32'h0);
    reset_n = 1'b1;
    tick(5);
    check("idle_after_reset", {29'h0, rx_state}, {29'h0, RX_IDLE});
    check("idle_busy", {31'h0, rx_busy}, 32'h0);

    // frame 0x35 with latency bound
    ferr0 = ferr_pulses;
    exp_q.push_back(8'h35);
    n = 0;
    fork
      send_byte(8'h35, 1'b1);
      begin
        while (!rx_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    check("x35_latency_ok", {31'h0, (n >= 150 && n <= 155)}, 32'h1);
    check("x35_valid", {31'h0, rx_valid}, 32'h1);
    check_byte("x35_data");
    check("x35_no_ferr", ferr_pulses - ferr0, 0);
    check("x35_no_overrun", {31'h0, rx_overrun}, 32'h0);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("x35_ack_clears", {31'h0, rx_valid}, 32'h0);
    tick(4);

    // 4-cycle low glitch on idle line
    vr0 = valid_rises;
    busy_cnt = 0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 3) uart_rxd = 1'b1;
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_len", {31'h0, (busy_cnt >= 1 && busy_cnt <= 11)}, 32'h1);
    check("glitch_no_valid", valid_rises - vr0, 0);
    check("glitch_idle", {31'h0, rx_busy}, 32'h0);

    // 0xA5 with bad stop bit, break held, then 0x5A
    ferr0 = ferr_pulses;
    vr0   = valid_rises;
    send_byte(8'hA5, 1'b0);
    tick(40);
    check("break_still_busy", {31'h0, rx_busy}, 32'h1);
    uart_rxd = 1'b1;
    tick(20);
    check("ferr_one_pulse", ferr_pulses - ferr0, 1);
    check("ferr_one_cycle", ferr_wide, 0);
    check("xa5_no_valid", valid_rises - vr0, 0);
    check("break_back_idle", {31'h0, rx_busy}, 32'h0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    tick(4);
    check("x5a_valid", {31'h0, rx_valid}, 32'h1);
    check_byte("x5a_data");
    check("x5a_no_new_ferr", ferr_pulses - ferr0, 1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(4);

    // overrun: 0x11 then 0x22 without ack
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    tick(4);
    send_byte(8'h22, 1'b1);
    tick(4);
    check_byte("ovr_data_kept");
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_flag", {31'h0, rx_overrun}, 32'h1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("ovr_ack_valid", {31'h0, rx_valid}, 32'h0);
    check("ovr_ack_flag", {31'h0, rx_overrun}, 32'h0);
    tick(4);

    // ack in the completion cycle of 0x22 with 0x11 pending
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    tick(4);
    check_byte("same_cyc_first");
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        // stop sample falls in the cycle ending 155 edges after the start drive
        repeat (154) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    tick(2);
    check_byte("same_cyc_data");
    check("same_cyc_valid", {31'h0, rx_valid}, 32'h1);
    check("same_cyc_no_ovr", {31'h0, rx_overrun}, 32'h0);

    // reset during data bit 4 of 0xFF, then 0x0F
    fork
      send_byte(8'hFF, 1'b1);
      begin
        tick(85);
        reset_n = 1'b0;
        #2;
        check("midframe_reset_outputs",
              {24'h0, rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun}, 32'h0);
        tick(3);
        reset_n = 1'b1;
      end
    join
    vr0 = valid_rises;
    tick(20);
    check("xff_not_delivered", valid_rises - vr0, 0);
    check("xff_idle", {31'h0, rx_busy}, 32'h0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    tick(4);
    check("x0f_one_delivery", valid_rises - vr0, 1);
    check_byte("x0f_data");
    check("x0f_valid", {31'h0, rx_valid}, 32'h1);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
